// File: rtl/axi_mem_arbiter_if.sv
// One AXI4 port (AR/AW/W/B/R); IW is the ID width carried on this port.
// "master" drives requests and W, "slave" answers with ready, R and B.
interface axi_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int IW     = 5
);
    logic              ar_valid;
    logic              ar_ready;
    logic [ADDR_W-1:0] ar_addr;
    logic [IW-1:0]     ar_id;
    logic [7:0]        ar_len;
    logic [2:0]        ar_size;
    logic [1:0]        ar_burst;

    logic              aw_valid;
    logic              aw_ready;
    logic [ADDR_W-1:0] aw_addr;
    logic [IW-1:0]     aw_id;
    logic [7:0]        aw_len;
    logic [2:0]        aw_size;
    logic [1:0]        aw_burst;

    logic                w_valid;
    logic                w_ready;
    logic [DATA_W-1:0]   w_data;
    logic [DATA_W/8-1:0] w_strb;
    logic                w_last;

    logic          b_valid;
    logic          b_ready;
    logic [IW-1:0] b_id;
    logic [1:0]    b_resp;

    logic              r_valid;
    logic              r_ready;
    logic [IW-1:0]     r_id;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_resp;
    logic              r_last;

    modport master (
        output ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst,
        input  ar_ready,
        output aw_valid, aw_addr, aw_id, aw_len, aw_size, aw_burst,
        input  aw_ready,
        output w_valid, w_data, w_strb, w_last,
        input  w_ready,
        input  b_valid, b_id, b_resp,
        output b_ready,
        input  r_valid, r_id, r_data, r_resp, r_last,
        output r_ready
    );

    modport slave (
        input  ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst,
        output ar_ready,
        input  aw_valid, aw_addr, aw_id, aw_len, aw_size, aw_burst,
        output aw_ready,
        input  w_valid, w_data, w_strb, w_last,
        output w_ready,
        output b_valid, b_id, b_resp,
        input  b_ready,
        output r_valid, r_id, r_data, r_resp, r_last,
        input  r_ready
    );
endinterface

// File: rtl/axi_mem_arbiter.sv
// Two-master to one-slave AXI4 arbiter: round-robin AR/AW, W steered in
// AW grant order, R/B routed back by the ID MSB this block prepends.
module axi_mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 64,
    parameter int ID_W        = 5,
    parameter int WFIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    axi_mem_arbiter_if.slave  m0,
    axi_mem_arbiter_if.slave  m1,
    axi_mem_arbiter_if.master s,
    output logic              busy
);
    localparam int PW = $clog2(WFIFO_DEPTH);
    localparam logic [PW:0]   CNT_ONE  = 1;
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(WFIFO_DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = 1;

    typedef enum logic {IDLE, GRANT} arb_st_e;

    arb_st_e ar_st, ar_st_nx, aw_st, aw_st_nx;
    logic    ar_gnt, ar_gnt_nx, ar_rr, ar_rr_nx;
    logic    aw_gnt, aw_gnt_nx, aw_rr, aw_rr_nx;

    logic [7:0] rd_cnt, wr_cnt;
    logic       rd_inc, rd_dec, wr_inc, wr_dec;

    logic [WFIFO_DEPTH-1:0] wq;
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [PW:0]            wcnt;
    logic                   w_full, w_empty, w_sel, w_push, w_pop;

    logic [ADDR_W-1:0] ar_addr_m, aw_addr_m;
    logic [DATA_W-1:0] w_data_m;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ar_st  <= IDLE;
            ar_gnt <= 1'b0;
            ar_rr  <= 1'b0;
            aw_st  <= IDLE;
            aw_gnt <= 1'b0;
            aw_rr  <= 1'b0;
        end else begin
            ar_st  <= ar_st_nx;
            ar_gnt <= ar_gnt_nx;
            ar_rr  <= ar_rr_nx;
            aw_st  <= aw_st_nx;
            aw_gnt <= aw_gnt_nx;
            aw_rr  <= aw_rr_nx;
        end
    end

    // rr = 0 favours m0 when both request; it flips to the loser on handshake
    always_comb begin
        ar_st_nx    = ar_st;
        ar_gnt_nx   = ar_gnt;
        ar_rr_nx    = ar_rr;
        s.ar_valid  = 1'b0;
        m0.ar_ready = 1'b0;
        m1.ar_ready = 1'b0;
        unique case (ar_st)
            IDLE: begin
                if ((m0.ar_valid || m1.ar_valid) && rd_cnt != 8'hFF) begin
                    ar_gnt_nx = (m0.ar_valid && m1.ar_valid) ? ar_rr : m1.ar_valid;
                    ar_st_nx  = GRANT;
                end
            end
            GRANT: begin
                s.ar_valid  = 1'b1;
                m0.ar_ready = !ar_gnt && s.ar_ready;
                m1.ar_ready = ar_gnt && s.ar_ready;
                if (s.ar_ready) begin
                    ar_st_nx = IDLE;
                    ar_rr_nx = !ar_gnt;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        aw_st_nx    = aw_st;
        aw_gnt_nx   = aw_gnt;
        aw_rr_nx    = aw_rr;
        s.aw_valid  = 1'b0;
        m0.aw_ready = 1'b0;
        m1.aw_ready = 1'b0;
        unique case (aw_st)
            IDLE: begin
                if ((m0.aw_valid || m1.aw_valid) && !w_full && wr_cnt != 8'hFF) begin
                    aw_gnt_nx = (m0.aw_valid && m1.aw_valid) ? aw_rr : m1.aw_valid;
                    aw_st_nx  = GRANT;
                end
            end
            GRANT: begin
                s.aw_valid  = 1'b1;
                m0.aw_ready = !aw_gnt && s.aw_ready;
                m1.aw_ready = aw_gnt && s.aw_ready;
                if (s.aw_ready) begin
                    aw_st_nx = IDLE;
                    aw_rr_nx = !aw_gnt;
                end
            end
            default: ;
        endcase
    end

    assign ar_addr_m  = ar_gnt ? m1.ar_addr : m0.ar_addr;
    assign s.ar_addr  = ar_addr_m;
    assign s.ar_id    = {ar_gnt, ar_gnt ? m1.ar_id : m0.ar_id};
    assign s.ar_len   = ar_gnt ? m1.ar_len : m0.ar_len;
    assign s.ar_size  = ar_gnt ? m1.ar_size : m0.ar_size;
    assign s.ar_burst = ar_gnt ? m1.ar_burst : m0.ar_burst;

    assign aw_addr_m  = aw_gnt ? m1.aw_addr : m0.aw_addr;
    assign s.aw_addr  = aw_addr_m;
    assign s.aw_id    = {aw_gnt, aw_gnt ? m1.aw_id : m0.aw_id};
    assign s.aw_len   = aw_gnt ? m1.aw_len : m0.aw_len;
    assign s.aw_size  = aw_gnt ? m1.aw_size : m0.aw_size;
    assign s.aw_burst = aw_gnt ? m1.aw_burst : m0.aw_burst;

    // W grant FIFO: one bit per accepted AW naming the master owing the data
    assign w_full  = (wcnt == CNT_FULL);
    assign w_empty = (wcnt == '0);
    assign w_sel   = wq[rd_ptr];
    assign w_push  = s.aw_valid && s.aw_ready;
    assign w_pop   = s.w_valid && s.w_ready && s.w_last;

    assign w_data_m    = w_sel ? m1.w_data : m0.w_data;
    assign s.w_data    = w_data_m;
    assign s.w_strb    = w_sel ? m1.w_strb : m0.w_strb;
    assign s.w_last    = w_sel ? m1.w_last : m0.w_last;
    assign s.w_valid   = !w_empty && (w_sel ? m1.w_valid : m0.w_valid);
    assign m0.w_ready  = !w_empty && !w_sel && s.w_ready;
    assign m1.w_ready  = !w_empty && w_sel && s.w_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wq     <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            wcnt   <= '0;
        end else begin
            if (w_push) begin
                wq[wr_ptr] <= aw_gnt;
                wr_ptr     <= wr_ptr + PTR_ONE;
            end
            if (w_pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            unique case ({w_push, w_pop})
                2'b10:   wcnt <= wcnt + CNT_ONE;
                2'b01:   wcnt <= wcnt - CNT_ONE;
                default: ;
            endcase
        end
    end

    // Return paths are gated by reset so no valid/ready leaks out during it
    assign m0.r_valid = reset_n && s.r_valid && !s.r_id[ID_W];
    assign m1.r_valid = reset_n && s.r_valid && s.r_id[ID_W];
    assign s.r_ready  = reset_n && (s.r_id[ID_W] ? m1.r_ready : m0.r_ready);
    assign m0.r_id    = s.r_id[ID_W-1:0];
    assign m1.r_id    = s.r_id[ID_W-1:0];
    assign m0.r_data  = s.r_data;
    assign m1.r_data  = s.r_data;
    assign m0.r_resp  = s.r_resp;
    assign m1.r_resp  = s.r_resp;
    assign m0.r_last  = s.r_last;
    assign m1.r_last  = s.r_last;

    assign m0.b_valid = reset_n && s.b_valid && !s.b_id[ID_W];
    assign m1.b_valid = reset_n && s.b_valid && s.b_id[ID_W];
    assign s.b_ready  = reset_n && (s.b_id[ID_W] ? m1.b_ready : m0.b_ready);
    assign m0.b_id    = s.b_id[ID_W-1:0];
    assign m1.b_id    = s.b_id[ID_W-1:0];
    assign m0.b_resp  = s.b_resp;
    assign m1.b_resp  = s.b_resp;

    assign rd_inc = s.ar_valid && s.ar_ready;
    assign rd_dec = s.r_valid && s.r_ready && s.r_last;
    assign wr_inc = s.aw_valid && s.aw_ready;
    assign wr_dec = s.b_valid && s.b_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
            busy   <= 1'b0;
        end else begin
            unique case ({rd_inc, rd_dec})
                2'b10:   rd_cnt <= rd_cnt + 8'd1;
                2'b01:   rd_cnt <= rd_cnt - 8'd1;
                default: ;
            endcase
            unique case ({wr_inc, wr_dec})
                2'b10:   wr_cnt <= wr_cnt + 8'd1;
                2'b01:   wr_cnt <= wr_cnt - 8'd1;
                default: ;
            endcase
            busy <= (ar_st != IDLE) || (aw_st != IDLE) || !w_empty ||
                    (rd_cnt != '0) || (wr_cnt != '0);
        end
    end
endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Directed bench for axi_mem_arbiter: reset, AR round-robin, W ordering,
// W FIFO full back-pressure and R/B return routing.
module tb_axi_mem_arbiter;
    logic clock = 1'b0;
    logic reset_n;
    logic busy;
    int   total = 0;
    int   bad   = 0;

    always #5 clock = ~clock;

    axi_mem_arbiter_if #(.ADDR_W(32), .DATA_W(64), .IW(5)) m0_if ();
    axi_mem_arbiter_if #(.ADDR_W(32), .DATA_W(64), .IW(5)) m1_if ();
    axi_mem_arbiter_if #(.ADDR_W(32), .DATA_W(64), .IW(6)) s_if ();

    axi_mem_arbiter #(
        .ADDR_W(32), .DATA_W(64), .ID_W(5), .WFIFO_DEPTH(4)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .m0     (m0_if),
        .m1     (m1_if),
        .s      (s_if),
        .busy   (busy)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        m0_if.ar_valid = 0; m0_if.ar_addr = 32'h1000; m0_if.ar_id = 0;
        m0_if.ar_len = 0; m0_if.ar_size = 3; m0_if.ar_burst = 1;
        m0_if.aw_valid = 0; m0_if.aw_addr = 32'h2000; m0_if.aw_id = 0;
        m0_if.aw_len = 0; m0_if.aw_size = 3; m0_if.aw_burst = 1;
        m0_if.w_valid = 0; m0_if.w_data = 0; m0_if.w_strb = 8'hFF;
        m0_if.w_last = 0; m0_if.b_ready = 0; m0_if.r_ready = 0;
        m1_if.ar_valid = 0; m1_if.ar_addr = 32'h3000; m1_if.ar_id = 0;
        m1_if.ar_len = 0; m1_if.ar_size = 3; m1_if.ar_burst = 1;
        m1_if.aw_valid = 0; m1_if.aw_addr = 32'h4000; m1_if.aw_id = 0;
        m1_if.aw_len = 0; m1_if.aw_size = 3; m1_if.aw_burst = 1;
        m1_if.w_valid = 0; m1_if.w_data = 0; m1_if.w_strb = 8'hFF;
        m1_if.w_last = 0; m1_if.b_ready = 0; m1_if.r_ready = 0;
        s_if.ar_ready = 0; s_if.aw_ready = 0; s_if.w_ready = 0;
        s_if.b_valid = 0; s_if.b_id = 0; s_if.b_resp = 0;
        s_if.r_valid = 0; s_if.r_id = 0; s_if.r_data = 0;
        s_if.r_resp = 0; s_if.r_last = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    logic [63:0] w_exp [6];
    logic        exp_msb;
    int          n, m0i, m1i, hs;
    logic        a0, a1, w0, w1;

    initial begin
        idle_inputs();
        reset_n = 1'b0;
        step();
        step();
        check("rst_ar_valid", s_if.ar_valid, 0);
        check("rst_busy", busy, 0);

        // one m0 grant so rr points at m1, then a held m1 grant
        reset_n = 1'b1;
        step();
        m0_if.ar_valid = 1; m0_if.ar_id = 5'h03;
        step();
        check("ar_g0_valid", s_if.ar_valid, 1);
        check("ar_g0_id", s_if.ar_id, 6'h03);
        s_if.ar_ready = 1;
        #1;
        check("ar_g0_ready", m0_if.ar_ready, 1);
        step();
        s_if.ar_ready = 0;
        m1_if.ar_valid = 1; m1_if.ar_id = 5'h11;
        step();
        check("ar_g1_id", s_if.ar_id, 6'h31);
        check("ar_g1_m0rdy", m0_if.ar_ready, 0);
        check("busy_on", busy, 1);
        s_if.ar_ready = 1;
        reset_n = 1'b0;
        #1;
        check("rst_mid_valid", s_if.ar_valid, 0);
        check("rst_mid_ready", m1_if.ar_ready, 0);
        check("rst_mid_busy", busy, 0);
        s_if.ar_ready = 0;
        step();
        reset_n = 1'b1;
        step();
        check("rr_after_rst", s_if.ar_id, 6'h03);

        // contention: six alternating grants, idle cycle between them
        do_reset();
        m0_if.ar_valid = 1; m0_if.ar_id = 5'h0A;
        m1_if.ar_valid = 1; m1_if.ar_id = 5'h15;
        s_if.ar_ready = 1;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k % 2 == 1) begin
                exp_msb = ((k - 1) / 2) % 2 == 1;
                check("cont_valid", s_if.ar_valid, 1);
                check("cont_id", s_if.ar_id,
                      exp_msb ? 64'h35 : 64'h0A);
                check("cont_loser_rdy",
                      exp_msb ? m0_if.ar_ready : m1_if.ar_ready, 0);
            end else begin
                check("cont_gap", s_if.ar_valid, 0);
            end
        end

        // W ordering: m1 AW len=3 first, m0 AW len=1 second
        do_reset();
        w_exp[0] = 64'hB0; w_exp[1] = 64'hB1;
        w_exp[2] = 64'hB2; w_exp[3] = 64'hB3;
        w_exp[4] = 64'hA0; w_exp[5] = 64'hA1;
        s_if.aw_ready = 1; s_if.w_ready = 1;
        m1_if.aw_valid = 1; m1_if.aw_len = 3; m1_if.aw_id = 5'h02;
        m0_if.aw_len = 1; m0_if.aw_id = 5'h04;
        n = 0; m0i = 0; m1i = 0;
        for (int cyc = 0; cyc < 30 && n < 6; cyc++) begin
            m0_if.w_valid = m0i < 2;
            m0_if.w_data  = 64'hA0 + 64'(m0i);
            m0_if.w_last  = m0i == 1;
            m1_if.w_valid = cyc >= 2 && m1i < 4;
            m1_if.w_data  = 64'hB0 + 64'(m1i);
            m1_if.w_last  = m1i == 3;
            #1;
            a0 = m0_if.aw_valid && m0_if.aw_ready;
            a1 = m1_if.aw_valid && m1_if.aw_ready;
            w0 = m0_if.w_valid && m0_if.w_ready;
            w1 = m1_if.w_valid && m1_if.w_ready;
            if (s_if.w_valid) begin
                check("w_data", s_if.w_data, w_exp[n]);
                check("w_last", s_if.w_last, (n == 3 || n == 5) ? 1 : 0);
                if (n < 4)
                    check("w_m0_held", m0_if.w_ready, 0);
                n++;
            end
            step();
            if (a1) begin
                m1_if.aw_valid = 0;
                m0_if.aw_valid = 1;
            end
            if (a0) m0_if.aw_valid = 0;
            if (w0) m0i++;
            if (w1) m1i++;
        end
        check("w_beats", n, 6);

        // FIFO full: four AWs accepted with no W, fifth held off
        do_reset();
        s_if.aw_ready = 1;
        m0_if.aw_valid = 1;
        hs = 0;
        for (int k = 0; k < 11; k++) begin
            if (s_if.aw_valid && s_if.aw_ready) hs++;
            step();
        end
        check("full_aw_count", hs, 4);
        check("full_blocked", s_if.aw_valid, 0);
        s_if.w_ready = 1;
        m0_if.w_valid = 1; m0_if.w_last = 1; m0_if.w_data = 64'h55;
        #1;
        check("full_w_fwd", s_if.w_valid, 1);
        step();
        m0_if.w_valid = 0;
        step();
        check("full_aw_fifth", s_if.aw_valid, 1);

        // R/B routing by ID MSB
        do_reset();
        m1_if.ar_valid = 1; m1_if.ar_id = 5'h05;
        s_if.ar_ready = 1;
        step();
        check("rt_ar_id", s_if.ar_id, 6'h25);
        step();
        m1_if.ar_valid = 0; s_if.ar_ready = 0;
        s_if.r_valid = 1; s_if.r_id = 6'b1_00101;
        s_if.r_data = 64'hD0; s_if.r_last = 0;
        m0_if.r_ready = 1; m1_if.r_ready = 0;
        #1;
        check("rt_m1_valid", m1_if.r_valid, 1);
        check("rt_m0_valid", m0_if.r_valid, 0);
        check("rt_m1_id", m1_if.r_id, 5'b00101);
        check("rt_ready_lo", s_if.r_ready, 0);
        check("rt_busy", busy, 1);
        m1_if.r_ready = 1;
        #1;
        check("rt_ready_hi", s_if.r_ready, 1);
        check("rt_data0", m1_if.r_data, 64'hD0);
        step();
        s_if.r_data = 64'hD1; s_if.r_last = 1;
        #1;
        check("rt_last", m1_if.r_last, 1);
        step();
        s_if.r_valid = 0; s_if.r_last = 0;
        step();
        check("rt_busy_fall", busy, 0);
        s_if.b_valid = 1; s_if.b_id = 6'h07; m0_if.b_ready = 0;
        #1;
        check("b_m0_valid", m0_if.b_valid, 1);
        check("b_m1_valid", m1_if.b_valid, 0);
        check("b_m0_id", m0_if.b_id, 5'h07);
        check("b_ready", s_if.b_ready, 0);
        s_if.b_valid = 0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
